// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle: master drives the contact lines, slave is the scanner.
// Event outputs are single-cycle pulses with no backpressure, so a consumer must sample every cycle.
interface keypad_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CODE_W = $clog2(ROWS * COLS);

  logic [ROWS-1:0]   H;
  logic [COLS-1:0]   V;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_repeat;
  logic              key_held;
  logic              key_release;
  logic              multi_err;

  modport master (
    output H, V,
    input  key_code, key_valid, key_repeat, key_held, key_release, multi_err
  );

  modport slave (
    input  H, V,
    output key_code, key_valid, key_repeat, key_held, key_release, multi_err
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// Keypad scanner: 2-flop sync, press/release debounce, linear key code, optional auto-repeat.
// Press/release events appear DB_CYCLES+3 cycles after the pins settle; no backpressure, events are pulses.
module keypad_scan_debounce #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DB_CYCLES  = 16,
  parameter int REPEAT_DLY = 0,
  parameter int REPEAT_PER = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.slave  kp
);

  localparam int CODE_W  = $clog2(ROWS * COLS);
  localparam int CNT_MAX = (DB_CYCLES > REPEAT_DLY) ? DB_CYCLES : REPEAT_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RELOAD  = (REPEAT_PER >= REPEAT_DLY) ? 0 : REPEAT_DLY - REPEAT_PER;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_C       = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] RPT_DLY_C  = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] RPT_LOAD_C = CNT_W'(RELOAD);
  localparam logic [ROWS-1:0]  H_ONE      = ROWS'(1);
  localparam logic [COLS-1:0]  V_ONE      = COLS'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE_DB} state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   h_meta_q, h_meta_d, h_s_q, h_s_d;
  logic [COLS-1:0]   v_meta_q, v_meta_d, v_s_q, v_s_d;
  logic [CODE_W-1:0] cand_q, cand_d, code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, rpt_q, rpt_d;
  logic              valid_q, valid_d, repeat_q, repeat_d;
  logic              held_q, held_d, release_q, release_d;
  logic              multi_q, multi_d;

  logic              pressed, h_single, v_single, single;
  logic [CODE_W-1:0] row_idx, col_idx, code_s;

  always_comb begin
    h_meta_d  = kp.H;
    v_meta_d  = kp.V;
    h_s_d     = h_meta_q;
    v_s_d     = v_meta_q;

    pressed   = |h_s_q;
    h_single  = (h_s_q != '0) && ((h_s_q & (h_s_q - H_ONE)) == '0);
    v_single  = (v_s_q != '0) && ((v_s_q & (v_s_q - V_ONE)) == '0);
    single    = h_single && v_single;

    row_idx   = '0;
    col_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (h_s_q[i]) row_idx = CODE_W'(i);
    end
    for (int j = 0; j < COLS; j++) begin
      if (v_s_q[j]) col_idx = CODE_W'(j);
    end
    code_s    = row_idx * CODE_W'(COLS) + col_idx;

    state_d   = state_q;
    cand_d    = cand_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    held_d    = held_q;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    multi_d   = pressed && !single;

    case (state_q)
      IDLE: begin
        if (pressed && single) begin
          state_d = DEBOUNCE;
          cand_d  = code_s;
          cnt_d   = CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (!pressed || !single || (code_s != cand_q)) begin
          state_d = IDLE;
        end else if (cnt_q == DB_C) begin
          state_d = PRESSED;
          code_d  = cand_q;
          valid_d = 1'b1;
          held_d  = 1'b1;
          rpt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        // A different or multi-key pattern while held is ignored; only a full release leaves.
        if (!pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = CNT_ONE;
        end else if (REPEAT_DLY > 0) begin
          if ((rpt_q + CNT_ONE) == RPT_DLY_C) begin
            valid_d  = 1'b1;
            repeat_d = 1'b1;
            rpt_d    = RPT_LOAD_C;
          end else begin
            rpt_d    = rpt_q + CNT_ONE;
          end
        end
      end
      RELEASE_DB: begin
        // Release bounce returns to PRESSED with the repeat timer left where it was.
        if (pressed) begin
          state_d   = PRESSED;
        end else if (cnt_q == DB_C) begin
          state_d   = IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      h_meta_q  <= '0;
      h_s_q     <= '0;
      v_meta_q  <= '0;
      v_s_q     <= '0;
      cand_q    <= '0;
      code_q    <= '0;
      cnt_q     <= '0;
      rpt_q     <= '0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      release_q <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_meta_q  <= h_meta_d;
      h_s_q     <= h_s_d;
      v_meta_q  <= v_meta_d;
      v_s_q     <= v_s_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      valid_q   <= valid_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      release_q <= release_d;
      multi_q   <= multi_d;
    end
  end

  assign kp.key_code    = code_q;
  assign kp.key_valid   = valid_q;
  assign kp.key_repeat  = repeat_q;
  assign kp.key_held    = held_q;
  assign kp.key_release = release_q;
  assign kp.multi_err   = multi_q;

endmodule
